// File: rtl/dmem_responder.sv
// Data-memory responder: req/addr_ok handshake, programmable wait states, and a
// word RAM with big-endian byte lanes that answers with a registered data_ok pulse.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        resp_err
);
    localparam int         DEPTH       = 1 << ADDR_WIDTH;
    localparam bit         NO_WAIT     = (WAIT_CYCLES == 0);
    localparam int         WAIT_INIT_I = NO_WAIT ? 0 : WAIT_CYCLES - 1;
    localparam logic [3:0] WAIT_INIT   = 4'(WAIT_INIT_I);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    data_ok_q;
    logic                    resp_err_q;
    logic [31:0]             rdata_q;
    logic                    wr_q;
    logic [1:0]              size_q;
    logic [1:0]              off_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    accept;
    logic                    access;
    logic                    acc_wr;
    logic [1:0]              acc_size;
    logic [1:0]              acc_off;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic                    acc_err;
    logic [3:0]              acc_be;
    logic                    mem_we;
    logic [31:0]             rdata_d;
    logic                    unused_addr;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic m;
        case (sz)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction

    // Lane enable bit 3 maps to [31:24]: offset 0 is the most significant byte.
    function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b1000 >> off;
            2'b01:   be = off[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    assign addr_ok     = (state_q != S_WAIT);
    assign accept      = req && addr_ok;
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    // With no wait states the access happens on the acceptance edge itself,
    // so it must use the live request rather than the latched copy.
    always_comb begin
        access    = 1'b0;
        acc_wr    = wr_q;
        acc_size  = size_q;
        acc_off   = off_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (NO_WAIT) begin
            access    = accept;
            acc_wr    = wr;
            acc_size  = size;
            acc_off   = addr[1:0];
            acc_idx   = addr[ADDR_WIDTH+1:2];
            acc_wdata = wdata;
        end else begin
            access = (state_q == S_WAIT) && (cnt_q == 4'd0);
        end
        acc_err = misaligned(acc_size, acc_off);
        acc_be  = lane_en(acc_size, acc_off);
        mem_we  = access && acc_wr && !acc_err;
        rdata_d = (acc_wr || acc_err) ? 32'h0 : mem_q[acc_idx];
    end

    // RAM is never cleared; a store is blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= wr;
            size_q  <= size;
            off_q   <= addr[1:0];
            idx_q   <= addr[ADDR_WIDTH+1:2];
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            data_ok_q  <= 1'b0;
            resp_err_q <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            data_ok_q <= access;
            if (access) begin
                resp_err_q <= acc_err;
                rdata_q    <= rdata_d;
            end
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (req) begin
                        if (NO_WAIT) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_ok  = data_ok_q;
    assign resp_err = resp_err_q;
    assign rdata    = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none,
// checked every cycle against a transaction-level memory model plus directed literals.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_s  [2];
    logic        wr_s   [2];
    logic [1:0]  sz_s   [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic        aok_s  [2];
    logic        dok_s  [2];
    logic [31:0] rd_s   [2];
    logic        err_s  [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst_n), .req(req_s[0]), .wr(wr_s[0]), .size(sz_s[0]),
        .addr(addr_s[0]), .wdata(wd_s[0]), .addr_ok(aok_s[0]), .data_ok(dok_s[0]),
        .rdata(rd_s[0]), .resp_err(err_s[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst_n), .req(req_s[1]), .wr(wr_s[1]), .size(sz_s[1]),
        .addr(addr_s[1]), .wdata(wd_s[1]), .addr_ok(aok_s[1]), .data_ok(dok_s[1]),
        .rdata(rd_s[1]), .resp_err(err_s[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic int wait_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    int          cyc = 0;
    logic [31:0] mmem [int];
    bit          m_pend [2] = '{0, 0};
    int          m_due  [2];
    logic        m_pwr  [2];
    logic [1:0]  m_psz  [2];
    logic [31:0] m_pa   [2];
    logic [31:0] m_pwd  [2];
    bit          e_aok  [2] = '{1, 1};
    bit          e_dok  [2] = '{0, 0};
    bit          e_err  [2] = '{0, 0};
    bit          e_known[2] = '{1, 1};
    logic [31:0] e_rd   [2] = '{32'h0, 32'h0};

    task automatic respond(input int i, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        int          key = i * 4096 + int'((a >> 2) & 32'h3FF);
        bit          mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        logic [31:0] m;
        e_dok[i]   = 1'b1;
        e_err[i]   = mis;
        e_known[i] = 1'b1;
        if (mis || w) e_rd[i] = 32'h0;
        else if (mmem.exists(key)) e_rd[i] = mmem[key];
        else begin e_known[i] = 1'b0; e_rd[i] = 32'h0; end
        if (w && !mis) begin
            case (sz)
                2'b00:   m = 32'hFF00_0000 >> (8 * a[1:0]);
                2'b01:   m = a[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                default: m = 32'hFFFF_FFFF;
            endcase
            if (mmem.exists(key)) mmem[key] = (mmem[key] & ~m) | (wd & m);
            else if (m == 32'hFFFF_FFFF) mmem[key] = wd;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_pend[i] = 1'b0;
                e_aok[i]  = 1'b1;
                e_dok[i]  = 1'b0;
                e_err[i]  = 1'b0;
                e_rd[i]   = 32'h0;
                e_known[i] = 1'b1;
            end else begin
                bit acc;
                acc = req_s[i] && e_aok[i];
                e_dok[i] = 1'b0;
                if (m_pend[i] && cyc == m_due[i]) begin
                    respond(i, m_pwr[i], m_psz[i], m_pa[i], m_pwd[i]);
                    m_pend[i] = 1'b0;
                end
                if (acc) begin
                    if (wait_of(i) == 0) begin
                        respond(i, wr_s[i], sz_s[i], addr_s[i], wd_s[i]);
                    end else begin
                        m_pend[i] = 1'b1;
                        m_due[i]  = cyc + wait_of(i);
                        m_pwr[i]  = wr_s[i];
                        m_psz[i]  = sz_s[i];
                        m_pa[i]   = addr_s[i];
                        m_pwd[i]  = wd_s[i];
                    end
                end
                e_aok[i] = !m_pend[i];
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("addr_ok[%0d]", i), {31'h0, aok_s[i]}, {31'h0, e_aok[i]});
            check($sformatf("data_ok[%0d]", i), {31'h0, dok_s[i]}, {31'h0, e_dok[i]});
            check($sformatf("resp_err[%0d]", i), {31'h0, err_s[i]}, {31'h0, e_err[i]});
            if (e_known[i]) check($sformatf("rdata[%0d]", i), rd_s[i], e_rd[i]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input int i, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        @(negedge clk);
        req_s[i] = 1'b1; wr_s[i] = w; sz_s[i] = sz; addr_s[i] = a; wd_s[i] = wd;
        while (!aok_s[i] && n < 50) begin @(negedge clk); n++; end
        if (!aok_s[i]) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_s[i] = 1'b0;
        lat = 1;
        while (!dok_s[i] && lat < 50) begin @(negedge clk); lat++; end
        rd = rd_s[i];
        er = err_s[i];
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] vals [4] = '{32'h1010_1010, 32'h2020_2020, 32'h3030_3030, 32'h4040_4040};
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; wr_s[i] = 1'b0; sz_s[i] = 2'b00; addr_s[i] = 32'h0; wd_s[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("reset_data_ok", {31'h0, dok_s[0]}, 32'h0);
        check("reset_addr_ok", {31'h0, aok_s[0]}, 32'h1);
        #1 rst_n = 1'b1;

        issue(0, 1'b1, 2'b10, 32'h40, 32'h1122_3344, rd, er, lat);
        check("st_word_lat", lat, 32'd3);
        check("st_word_rdata", rd, 32'h0);
        issue(0, 1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat);
        check("ld_word_lat", lat, 32'd3);
        check("ld_word_rdata", rd, 32'h1122_3344);
        check("ld_word_err", {31'h0, er}, 32'h0);

        issue(0, 1'b1, 2'b00, 32'h41, 32'h00AB_0000, rd, er, lat);
        issue(0, 1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat);
        check("byte_store", rd, 32'h11AB_3344);
        issue(0, 1'b1, 2'b01, 32'h42, 32'h0000_BEEF, rd, er, lat);
        issue(0, 1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat);
        check("half_store", rd, 32'h11AB_BEEF);

        issue(0, 1'b1, 2'b01, 32'h43, 32'h0000_5555, rd, er, lat);
        check("mis_half_err", {31'h0, er}, 32'h1);
        check("mis_half_rdata", rd, 32'h0);
        issue(0, 1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat);
        check("mis_no_write", rd, 32'h11AB_BEEF);
        issue(0, 1'b0, 2'b10, 32'h42, 32'h0, rd, er, lat);
        check("mis_word_err", {31'h0, er}, 32'h1);
        check("mis_word_rdata", rd, 32'h0);

        for (int k = 0; k < 4; k++) begin
            issue(1, 1'b1, 2'b10, 32'(4 * k), vals[k], rd, er, lat);
            check("w0_store_lat", lat, 32'd1);
        end
        @(negedge clk);
        req_s[1] = 1'b1; wr_s[1] = 1'b0; sz_s[1] = 2'b10; addr_s[1] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b_addr_ok", {31'h0, aok_s[1]}, 32'h1);
            check("b2b_data_ok", {31'h0, dok_s[1]}, 32'h1);
            check("b2b_rdata", rd_s[1], vals[k]);
            if (k < 3) addr_s[1] = 32'(4 * (k + 1));
            else       req_s[1] = 1'b0;
        end
        @(negedge clk);
        check("b2b_end", {31'h0, dok_s[1]}, 32'h0);

        issue(0, 1'b1, 2'b10, 32'h80, 32'h5566_7788, rd, er, lat);
        issue(0, 1'b0, 2'b10, 32'h80, 32'h0, rd, er, lat);
        check("pre_reset_load", rd, 32'h5566_7788);
        @(negedge clk);
        req_s[0] = 1'b1; wr_s[0] = 1'b1; sz_s[0] = 2'b10; addr_s[0] = 32'h80; wd_s[0] = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_s[0] = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_data_ok", {31'h0, dok_s[0]}, 32'h0);
        check("rst_rdata", rd_s[0], 32'h0);
        check("rst_err", {31'h0, err_s[0]}, 32'h0);
        check("rst_addr_ok", {31'h0, aok_s[0]}, 32'h1);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_no_resp", {31'h0, dok_s[0]}, 32'h0);
        end
        issue(0, 1'b0, 2'b10, 32'h80, 32'h0, rd, er, lat);
        check("rst_no_commit", rd, 32'h5566_7788);

        issue(0, 1'b1, 2'b10, 32'h1000, 32'hCAFE_F00D, rd, er, lat);
        issue(0, 1'b0, 2'b10, 32'h0, 32'h0, rd, er, lat);
        check("addr_wrap", rd, 32'hCAFE_F00D);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
